// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback handshake bundle between the pipeline and the hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 4
) ();
    localparam int NREG = 2 ** REG_ADDR_W;

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic [CNT_W-1:0]      issue_lat;
    logic [REG_ADDR_W-1:0] rs1_d;
    logic [REG_ADDR_W-1:0] rs2_d;
    logic                  rs1_used;
    logic                  rs2_used;
    logic                  pcsrc_e;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  stall_f;
    logic                  stall_d;
    logic                  flush_d;
    logic                  flush_e;
    logic [NREG-1:0]       pending_mask;

    modport master (
        output issue_valid, issue_rd, issue_lat,
        output rs1_d, rs2_d, rs1_used, rs2_used,
        output pcsrc_e, wb_valid, wb_rd,
        input  stall_f, stall_d, flush_d, flush_e,
        input  pending_mask
    );

    modport slave (
        input  issue_valid, issue_rd, issue_lat,
        input  rs1_d, rs2_d, rs1_used, rs2_used,
        input  pcsrc_e, wb_valid, wb_rd,
        output stall_f, stall_d, flush_d, flush_e,
        output pending_mask
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard generating stall/flush controls.
// Optional HAZARD_STALL_COUNT_EN adds a saturating stall_cycles counter.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave sb
`ifdef HAZARD_STALL_COUNT_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);
    localparam int NREG = 2 ** REG_ADDR_W;
    localparam logic [CNT_W-1:0] LAT_UNK = '1;

    logic [CNT_W-1:0] cnt [NREG];
    logic             rs1_hit;
    logic             rs2_hit;
    logic             rd_hit;
    logic             hazard;
    logic             accept;
    logic             stall;

    always_comb begin
        rs1_hit = sb.rs1_used && (sb.rs1_d != '0)
                  && (cnt[sb.rs1_d] != '0);
        rs2_hit = sb.rs2_used && (sb.rs2_d != '0)
                  && (cnt[sb.rs2_d] != '0);
        rd_hit  = (sb.issue_rd != '0)
                  && (cnt[sb.issue_rd] != '0);
        hazard  = sb.issue_valid
                  && (rs1_hit || rs2_hit || rd_hit);
        accept  = sb.issue_valid && !hazard
                  && !sb.pcsrc_e;
        stall   = hazard && !sb.pcsrc_e;
    end

    assign sb.stall_f = stall;
    assign sb.stall_d = stall;
    assign sb.flush_d = sb.pcsrc_e;
    assign sb.flush_e = sb.pcsrc_e || hazard;

    // Priority: reset, accepted issue, writeback, countdown.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (reset || i == 0) begin
                cnt[i] <= '0;
            end else if (accept
                && sb.issue_rd == REG_ADDR_W'(i)) begin
                cnt[i] <= sb.issue_lat;
            end else if (sb.wb_valid
                && sb.wb_rd == REG_ADDR_W'(i)) begin
                cnt[i] <= '0;
            end else if (cnt[i] != '0
                && cnt[i] != LAT_UNK) begin
                cnt[i] <= cnt[i] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        sb.pending_mask = '0;
        for (int i = 0; i < NREG; i++) begin
            sb.pending_mask[i] = (cnt[i] != '0);
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a ready-time reference model.
module tb_hazard_scoreboard;
    localparam int AW   = 5;
    localparam int CW   = 4;
    localparam int NREG = 32;
    localparam logic [CW-1:0] UNK = 4'hF;

    logic clk;
    logic reset;

    hazard_scoreboard_if #(.REG_ADDR_W(AW), .CNT_W(CW)) bus ();

`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] m_scnt;
`endif

    hazard_scoreboard #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (bus)
`ifdef HAZARD_STALL_COUNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    int checks;
    int errors;

    // Model: register r is pending while cyc < ready[r],
    // or indefinitely while unk[r] is set.
    longint cyc;
    longint ready [NREG];
    bit     unk   [NREG];
    logic   m_hz;
    logic   m_acc;
    logic   m_stall;
    logic [4:0]      e_ctl;
    logic [4:0]      g_ctl;
    logic [NREG-1:0] e_mask;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit pend(input logic [AW-1:0] r);
        return (r != '0) && (unk[r] || cyc < ready[r]);
    endfunction

    function automatic logic model_hazard();
        return bus.issue_valid
            && ((bus.rs1_used && pend(bus.rs1_d))
             || (bus.rs2_used && pend(bus.rs2_d))
             || pend(bus.issue_rd));
    endfunction

    always @(posedge clk) begin
        m_hz    = model_hazard();
        m_stall = m_hz && !bus.pcsrc_e;
        m_acc   = bus.issue_valid && !m_hz && !bus.pcsrc_e;
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                ready[i] = 0;
                unk[i]   = 1'b0;
            end
`ifdef HAZARD_STALL_COUNT_EN
            m_scnt = '0;
`endif
        end else begin
            if (bus.wb_valid && pend(bus.wb_rd)) begin
                unk[bus.wb_rd]   = 1'b0;
                ready[bus.wb_rd] = 0;
            end
            if (m_acc && bus.issue_rd != '0) begin
                unk[bus.issue_rd]   = (bus.issue_lat == UNK);
                ready[bus.issue_rd] = (bus.issue_lat == UNK) ? 0
                    : cyc + 1 + longint'(bus.issue_lat);
            end
`ifdef HAZARD_STALL_COUNT_EN
            if (m_stall && m_scnt != 32'hFFFF_FFFF)
                m_scnt = m_scnt + 32'd1;
`endif
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            m_hz   = model_hazard();
            e_ctl  = {m_hz && !bus.pcsrc_e,
                      m_hz && !bus.pcsrc_e,
                      bus.pcsrc_e, bus.pcsrc_e,
                      bus.pcsrc_e || m_hz};
            g_ctl  = {bus.stall_f, bus.stall_d,
                      bus.flush_d, bus.flush_d,
                      bus.flush_e};
            for (int i = 0; i < NREG; i++)
                e_mask[i] = pend(AW'(i));
            checks++;
            if (g_ctl !== e_ctl || bus.pending_mask !== e_mask) begin
                errors++;
                $display("FAIL cycle_cmp cyc=%0d ctl=%b/%b mask=%h/%h (got/exp)",
                         cyc, g_ctl, e_ctl, bus.pending_mask, e_mask);
            end
`ifdef HAZARD_STALL_COUNT_EN
            checks++;
            if (stall_cycles !== m_scnt) begin
                errors++;
                $display("FAIL stall_cnt_cmp got=%h exp=%h",
                         stall_cycles, m_scnt);
            end
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.issue_lat   = '0;
        bus.rs1_d       = '0;
        bus.rs2_d       = '0;
        bus.rs1_used    = 1'b0;
        bus.rs2_used    = 1'b0;
        bus.pcsrc_e     = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
    endtask

    task automatic issue(input logic [AW-1:0] rd, input logic [CW-1:0] lat,
                         input logic [AW-1:0] r1, input logic u1,
                         input logic [AW-1:0] r2, input logic u2);
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = rd;
        bus.issue_lat   = lat;
        bus.rs1_d       = r1;
        bus.rs1_used    = u1;
        bus.rs2_d       = r2;
        bus.rs2_used    = u2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int nst;

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        reset  = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_mask", bus.pending_mask, 32'h0);
        chk("rst_ctl", {bus.stall_f, bus.stall_d,
                        bus.flush_d, bus.flush_e}, 0);

        // Finite latency: lat=2 keeps x5 pending two cycles.
        issue(5, 2, 0, 0, 0, 0);
        #1 chk("lat2_issue_nostall", bus.stall_d, 0);
        tick();
        idle();
        #1 chk("lat2_mask_c1", bus.pending_mask[5], 1);
        tick();
        issue(0, 0, 5, 1, 0, 0);
        #1 chk("lat2_stall", bus.stall_d, 1);
        chk("lat2_mask_c2", bus.pending_mask[5], 1);
        tick();
        #1 chk("lat2_release", bus.stall_d, 0);
        chk("lat2_mask_c3", bus.pending_mask[5], 0);
        tick();

        // Unknown latency held until writeback.
        issue(7, UNK, 0, 0, 0, 0);
        tick();
        issue(0, 0, 0, 0, 7, 1);
        nst = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.stall_d) nst++;
            if (i == 19) begin
                bus.wb_valid = 1'b1;
                bus.wb_rd    = 7;
            end
            tick();
        end
        chk("unk_stall_cycles", nst, 20);
        bus.wb_valid = 1'b0;
        #1 chk("unk_release", bus.stall_d, 0);
        chk("unk_mask", bus.pending_mask[7], 0);
        tick();

        // x0 never pending.
        issue(0, 3, 0, 0, 0, 0);
        tick();
        issue(0, 0, 0, 1, 0, 1);
        #1 chk("x0_nostall", bus.stall_d, 0);
        chk("x0_mask", bus.pending_mask, 32'h0);
        tick();

        // Hazard coincident with taken branch.
        issue(3, 4, 0, 0, 0, 0);
        tick();
        issue(6, 5, 3, 1, 0, 0);
        bus.pcsrc_e = 1'b1;
        #1 chk("br_ctl", {bus.stall_d, bus.flush_d, bus.flush_e},
               32'h3);
        tick();
        idle();
        #1 chk("br_no_upd", bus.pending_mask[6], 0);
        issue(8, 2, 0, 0, 0, 0);
        bus.pcsrc_e = 1'b1;
        #1 chk("br_nohaz_ctl", {bus.stall_d, bus.flush_e}, 32'h1);
        tick();
        idle();
        #1 chk("br_nohaz_upd", bus.pending_mask[8], 0);

        // WAW.
        issue(4, 3, 0, 0, 0, 0);
        tick();
        issue(4, 1, 0, 0, 0, 0);
        #1 chk("waw_ctl", {bus.stall_d, bus.flush_e}, 32'h3);
        tick();
        idle();

        // Issue beats simultaneous writeback; wb clears finite count.
        issue(11, 3, 0, 0, 0, 0);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 11;
        tick();
        idle();
        #1 chk("iss_wins_wb", bus.pending_mask[11], 1);
        issue(12, 6, 0, 0, 0, 0);
        tick();
        idle();
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 12;
        tick();
        bus.wb_valid = 1'b0;
        #1 chk("wb_clr_finite", bus.pending_mask[12], 0);

        // lat=0 never pending.
        issue(14, 0, 0, 0, 0, 0);
        tick();
        issue(0, 0, 14, 1, 0, 0);
        #1 chk("lat0_mask", bus.pending_mask[14], 0);
        chk("lat0_nostall", bus.stall_d, 0);
        tick();
        idle();

        // Reset drops unknown-latency entry; late wb ignored.
        issue(9, UNK, 0, 0, 0, 0);
        tick();
        idle();
        #1 chk("x9_pending", bus.pending_mask[9], 1);
        reset = 1'b1;
        issue(13, 4, 0, 0, 0, 0);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 9;
        tick();
        reset = 1'b0;
        idle();
        #1 chk("rst_mid_mask", bus.pending_mask, 32'h0);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 9;
        tick();
        idle();
        #1 chk("late_wb_mask", bus.pending_mask, 32'h0);

`ifdef HAZARD_STALL_COUNT_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        issue(5, UNK, 0, 0, 0, 0);
        tick();
        issue(0, 0, 5, 1, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        #1 chk("scnt_4", stall_cycles, 32'd4);
        force dut.stall_cnt = 32'hFFFF_FFFE;
        m_scnt = 32'hFFFF_FFFE;
        #1 release dut.stall_cnt;
        for (int i = 0; i < 3; i++) tick();
        #1 chk("scnt_sat", stall_cycles, 32'hFFFF_FFFF);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5;
        tick();
        idle();
`endif

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
